sobel_stream_param: RTL and testbench

//  Parametrised streaming 3x3 Sobel edge filter between an input FIFO and an output FIFO.

---
 rtl/sobel_stream_param.sv | 181 ++++++++++++++++++
 tb/tb_sobel_stream_param.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_param.sv
// Streaming 3x3 Sobel filter between FWFT input and output FIFOs.
// Produces one output per input pixel, with optional binary thresholding.
module sobel_stream_param #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int PIX_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic [PIX_W-1:0] thresh,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [PIX_W-1:0] in_dout,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [PIX_W-1:0] out_din,
  output logic             busy,
  output logic             frame_done
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int LB = 2 * WIDTH + 3;
  localparam int CW = $clog2(N + 1);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int SW = PIX_W + 3;

  localparam logic [CW-1:0] FILL_LAST = CW'(WIDTH + 1);
  localparam logic [CW-1:0] READ_LAST = CW'(N - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    rd_cnt_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic             mode_q;
  logic [PIX_W-1:0] thresh_q;
  logic             frame_done_q;
  logic [PIX_W-1:0] lb_q [LB];

  logic             rd_step;
  logic             wr_step;
  logic             shift_en;
  logic [PIX_W-1:0] shift_in;
  logic [XW-1:0]    x_d;
  logic [YW-1:0]    y_d;

  always_comb begin
    rd_step = 1'b0;
    wr_step = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FILL:  rd_step = !in_empty;
        S_RUN: begin
          rd_step = !in_empty && !out_full;
          wr_step = rd_step;
        end
        S_FLUSH: wr_step = !out_full;
        default: ;
      endcase
    end
  end

  // Flush steps push zeros so the last rows still see a full window.
  assign shift_en = rd_step || wr_step;
  assign shift_in = rd_step ? in_dout : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LB; i++) lb_q[i] <= '0;
    end else if (shift_en) begin
      lb_q[0] <= shift_in;
      for (int i = 1; i < LB; i++) lb_q[i] <= lb_q[i-1];
    end
  end

  // Window centre (output p) sits WIDTH+1 entries behind the newest read.
  logic signed [SW-1:0] w00, w01, w02, w10, w12, w20, w21, w22;
  assign w00 = $signed({3'b000, lb_q[2*WIDTH+2]});
  assign w01 = $signed({3'b000, lb_q[2*WIDTH+1]});
  assign w02 = $signed({3'b000, lb_q[2*WIDTH]});
  assign w10 = $signed({3'b000, lb_q[WIDTH+2]});
  assign w12 = $signed({3'b000, lb_q[WIDTH]});
  assign w20 = $signed({3'b000, lb_q[2]});
  assign w21 = $signed({3'b000, lb_q[1]});
  assign w22 = $signed({3'b000, lb_q[0]});

  logic signed [SW-1:0] gx, gy, ax, ay;
  logic        [SW:0]   mag_sum;
  logic        [SW-1:0] mag;
  logic [PIX_W-1:0]     sat_pix;
  logic                 over_th;
  logic                 border;

  assign gx      = (w02 + (w12 <<< 1) + w22) - (w00 + (w10 <<< 1) + w20);
  assign gy      = (w20 + (w21 <<< 1) + w22) - (w00 + (w01 <<< 1) + w02);
  assign ax      = gx[SW-1] ? -gx : gx;
  assign ay      = gy[SW-1] ? -gy : gy;
  assign mag_sum = {1'b0, ax} + {1'b0, ay};
  assign mag     = mag_sum[SW:1];
  assign sat_pix = (|mag[SW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
  assign over_th = mag >= {3'b000, thresh_q};
  assign border  = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);

  assign out_din    = (wr_step && !border) ? (mode_q ? {PIX_W{over_th}} : sat_pix) : '0;
  assign in_rd_en   = rd_step;
  assign out_wr_en  = wr_step;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = y_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rd_cnt_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      mode_q       <= 1'b0;
      thresh_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          mode_q   <= mode;
          thresh_q <= thresh;
          rd_cnt_q <= '0;
          x_q      <= '0;
          y_q      <= '0;
          state_q  <= S_FILL;
        end
        S_FILL: begin
          if (rd_step) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rd_cnt_q == FILL_LAST) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (rd_step) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            x_q      <= x_d;
            y_q      <= y_d;
            if (rd_cnt_q == READ_LAST) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (wr_step) begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
              x_q          <= '0;
              y_q          <= '0;
              frame_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              x_q <= x_d;
              y_q <= y_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream_param.sv
// Bench for sobel_stream_param: 4x4 and 5x5 instances fed by FIFO models,
// outputs compared with a direct Sobel-on-image reference.
module tb_sobel_stream_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       mode_i = 1'b0;
  logic [7:0] thresh_i = 8'd0;

  logic       rd4, wr4, busy4, fd4;
  logic       empty4 = 1'b1, full4 = 1'b0;
  logic [7:0] dout4 = 8'd0, din4;
  logic       rd5, wr5, busy5, fd5;
  logic       empty5 = 1'b1, full5 = 1'b0;
  logic [7:0] dout5 = 8'd0, din5;

  int   n_assert = 0;
  int   n_fail = 0;
  int   gap_pct = 0;
  int   stall_pct = 0;
  logic force_full = 1'b0;

  logic [7:0] inq4[$], outq4[$], inq5[$], outq5[$];
  int   fd_cnt4 = 0, fd_cnt5 = 0, rdc4 = 0, rdc5 = 0;
  logic prev_wr4 = 1'b0, prev_wr5 = 1'b0;
  int   frame_pix [25];

  sobel_stream_param #(.WIDTH(4), .HEIGHT(4), .PIX_W(8)) dut4 (
    .clock(clk), .reset(reset), .mode(mode_i), .thresh(thresh_i),
    .in_rd_en(rd4), .in_empty(empty4), .in_dout(dout4),
    .out_wr_en(wr4), .out_full(full4), .out_din(din4),
    .busy(busy4), .frame_done(fd4)
  );

  sobel_stream_param #(.WIDTH(5), .HEIGHT(5), .PIX_W(8)) dut5 (
    .clock(clk), .reset(reset), .mode(mode_i), .thresh(thresh_i),
    .in_rd_en(rd5), .in_empty(empty5), .in_dout(dout5),
    .out_wr_en(wr5), .out_full(full5), .out_din(din5),
    .busy(busy5), .frame_done(fd5)
  );

  // FIFO models: drive on the falling edge, sample 1 ns later.
  always @(negedge clk) begin
    empty4 = (inq4.size() == 0) || ($urandom_range(99) < gap_pct);
    dout4  = (inq4.size() != 0) ? inq4[0] : 8'h00;
    full4  = force_full || ($urandom_range(99) < stall_pct);
    #1;
    if (rd4) begin
      n_assert++;
      if (empty4) begin n_fail++; $display("FAIL rd_while_empty4 got rd=1 want rd=0"); end
      else begin void'(inq4.pop_front()); rdc4++; end
    end
    n_assert++;
    if (wr4) begin
      if (full4) begin n_fail++; $display("FAIL wr_while_full4 got wr=1 want wr=0"); end
      else outq4.push_back(din4);
    end else if (din4 !== 8'h00) begin
      n_fail++; $display("FAIL idle_din4 got %0d want 0", din4);
    end
    if (fd4) begin
      fd_cnt4++;
      n_assert++;
      if (!prev_wr4 || busy4) begin
        n_fail++; $display("FAIL frame_done_timing4 got prev_wr=%0b busy=%0b want 1/0", prev_wr4, busy4);
      end
    end
    prev_wr4 = wr4;
  end

  always @(negedge clk) begin
    empty5 = (inq5.size() == 0) || ($urandom_range(99) < gap_pct);
    dout5  = (inq5.size() != 0) ? inq5[0] : 8'h00;
    full5  = force_full || ($urandom_range(99) < stall_pct);
    #1;
    if (rd5) begin
      n_assert++;
      if (empty5) begin n_fail++; $display("FAIL rd_while_empty5 got rd=1 want rd=0"); end
      else begin void'(inq5.pop_front()); rdc5++; end
    end
    n_assert++;
    if (wr5) begin
      if (full5) begin n_fail++; $display("FAIL wr_while_full5 got wr=1 want wr=0"); end
      else outq5.push_back(din5);
    end else if (din5 !== 8'h00) begin
      n_fail++; $display("FAIL idle_din5 got %0d want 0", din5);
    end
    if (fd5) begin
      fd_cnt5++;
      n_assert++;
      if (!prev_wr5 || busy5) begin
        n_fail++; $display("FAIL frame_done_timing5 got prev_wr=%0b busy=%0b want 1/0", prev_wr5, busy5);
      end
    end
    prev_wr5 = wr5;
  end

  function automatic int px(int w, int xx, int yy);
    return frame_pix[yy * w + xx];
  endfunction

  // Reference: Sobel on the whole image, border forced to zero.
  function automatic int model_pix(int w, int h, logic m, int th, int x, int y);
    int gx, gy, mag;
    if (x == 0 || y == 0 || x == w - 1 || y == h - 1) return 0;
    gx = (px(w, x+1, y-1) + 2 * px(w, x+1, y) + px(w, x+1, y+1))
       - (px(w, x-1, y-1) + 2 * px(w, x-1, y) + px(w, x-1, y+1));
    gy = (px(w, x-1, y+1) + 2 * px(w, x, y+1) + px(w, x+1, y+1))
       - (px(w, x-1, y-1) + 2 * px(w, x, y-1) + px(w, x+1, y-1));
    mag = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
    if (m) return (mag >= th) ? 255 : 0;
    return (mag > 255) ? 255 : mag;
  endfunction

  function automatic int out_size(int d);
    return (d == 4) ? outq4.size() : outq5.size();
  endfunction

  function automatic logic [7:0] out_at(int d, int i);
    return (d == 4) ? outq4[i] : outq5[i];
  endfunction

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b1;
    inq4.delete(); outq4.delete(); inq5.delete(); outq5.delete();
    fd_cnt4 = 0; fd_cnt5 = 0;
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic run_frame(input int d, input logic m, input logic [7:0] th,
                           input int stall_at, input string name);
    int n, budget, rd_before, wr_before, got_n, errs, exp_v;
    int stall_left;
    n = d * d;
    stall_left = stall_at;
    mode_i = m;
    thresh_i = th;
    pulse_reset();
    // Settings change after the latch point must not affect this frame.
    @(posedge clk); #2 mode_i = !m; thresh_i = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      if (d == 4) inq4.push_back(8'(frame_pix[i]));
      else        inq5.push_back(8'(frame_pix[i]));
    end
    budget = 0;
    while (out_size(d) < n && budget < 3000) begin
      @(posedge clk); #2;
      budget++;
      if (stall_left > 0 && out_size(d) == stall_left) begin
        rd_before = (d == 4) ? rdc4 : rdc5;
        wr_before = out_size(d);
        force_full = 1'b1;
        repeat (10) @(posedge clk);
        #2 force_full = 1'b0;
        n_assert++;
        if (((d == 4) ? rdc4 : rdc5) != rd_before || out_size(d) != wr_before) begin
          n_fail++;
          $display("FAIL %s_stall got rd=%0d wr=%0d want rd=%0d wr=%0d", name,
                   (d == 4) ? rdc4 : rdc5, out_size(d), rd_before, wr_before);
        end
        gap_pct = 40;
        stall_left = 0;
      end
    end
    if (budget >= 3000) begin
      n_fail++;
      $display("FAIL %s_timeout got %0d outputs want %0d", name, out_size(d), n);
    end
    repeat (3) @(posedge clk);
    #2;
    got_n = out_size(d);
    n_assert++;
    if (got_n != n) begin
      n_fail++; $display("FAIL %s_count got %0d want %0d", name, got_n, n);
    end
    errs = 0;
    for (int i = 0; i < n && i < got_n; i++) begin
      exp_v = model_pix(d, d, m, int'(th), i % d, i / d);
      n_assert++;
      if (out_at(d, i) !== 8'(exp_v)) begin
        n_fail++; errs++;
        $display("FAIL %s_pix%0d got %0d want %0d", name, i, out_at(d, i), exp_v);
      end
    end
    n_assert++;
    if (((d == 4) ? fd_cnt4 : fd_cnt5) != 1) begin
      n_fail++;
      $display("FAIL %s_frame_done got %0d pulses want 1", name, (d == 4) ? fd_cnt4 : fd_cnt5);
    end
    gap_pct = 0;
    stall_pct = 0;
    $display("frame %s: %0dx%0d mode=%0b thresh=%0d outputs=%0d pixel_errors=%0d",
             name, d, d, m, th, got_n, errs);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_assert += 6;
    if (rd4 !== 1'b0)    begin n_fail++; $display("FAIL rst_rd got %0b want 0", rd4); end
    if (wr4 !== 1'b0)    begin n_fail++; $display("FAIL rst_wr got %0b want 0", wr4); end
    if (din4 !== 8'h00)  begin n_fail++; $display("FAIL rst_din got %0d want 0", din4); end
    if (busy4 !== 1'b0)  begin n_fail++; $display("FAIL rst_busy4 got %0b want 0", busy4); end
    if (fd4 !== 1'b0)    begin n_fail++; $display("FAIL rst_fd got %0b want 0", fd4); end
    if (busy5 !== 1'b0)  begin n_fail++; $display("FAIL rst_busy5 got %0b want 0", busy5); end
    reset = 1'b0;
    #1;
    n_assert++;
    if (busy4 !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0b want 0", busy4); end
    @(posedge clk); #2;
    n_assert++;
    if (busy4 !== 1'b1) begin n_fail++; $display("FAIL fill_busy got %0b want 1", busy4); end
    $display("reset: checks done");
  endtask

  task automatic set_single();
    for (int i = 0; i < 25; i++) frame_pix[i] = 0;
    frame_pix[2 * 5 + 2] = 40;
  endtask

  task automatic test_uniform();
    for (int i = 0; i < 16; i++) frame_pix[i] = 100;
    run_frame(4, 1'b0, 8'd0, 0, "uniform");
  endtask

  task automatic test_columns();
    for (int i = 0; i < 16; i++) frame_pix[i] = ((i % 4) >= 2) ? 255 : 0;
    run_frame(4, 1'b0, 8'd0, 0, "columns");
  endtask

  task automatic test_single_mag();
    set_single();
    run_frame(5, 1'b0, 8'd0, 0, "single_mag");
  endtask

  task automatic test_single_thresh();
    set_single();
    run_frame(5, 1'b1, 8'd40, 0, "thresh40");
    run_frame(5, 1'b1, 8'd41, 0, "thresh41");
  endtask

  task automatic test_back_to_back_stall();
    for (int i = 0; i < 16; i++) frame_pix[i] = ((i % 4) >= 2) ? 255 : 0;
    run_frame(4, 1'b0, 8'd0, 3, "columns_stall");
  endtask

  task automatic test_reset_midframe();
    int start, budget;
    mode_i = 1'b0;
    pulse_reset();
    start = rdc5;
    for (int i = 0; i < 7; i++) inq5.push_back(8'($urandom));
    budget = 0;
    while (rdc5 - start < 7 && budget < 200) begin
      @(posedge clk); #2;
      budget++;
    end
    n_assert++;
    if (rdc5 - start != 7 || outq5.size() != 0) begin
      n_fail++;
      $display("FAIL partial_frame got reads=%0d writes=%0d want 7/0", rdc5 - start, outq5.size());
    end
    set_single();
    run_frame(5, 1'b0, 8'd0, 0, "after_reset");
  endtask

  task automatic test_random();
    int d;
    for (int k = 0; k < 6; k++) begin
      d = (k % 2 == 0) ? 4 : 5;
      for (int i = 0; i < d * d; i++)
        frame_pix[i] = ($urandom_range(1) == 1) ? (($urandom_range(1) == 1) ? 255 : 0)
                                                : int'($urandom_range(255));
      gap_pct = $urandom_range(30);
      stall_pct = $urandom_range(30);
      run_frame(d, 1'($urandom_range(1)), 8'($urandom), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_columns();
    test_single_mag();
    test_single_thresh();
    test_back_to_back_stall();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
